// File: rtl/i_cache_axi_bridge.sv
// i_cache_axi_bridge: single-outstanding SRAM-like to AXI bridge for I-cache misses
module i_cache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata_axi,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
    state_t      state;
    logic [1:0]  size_q, size_n;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        aw_done, w_done, aw_hs, w_hs, rd_done, wr_done;
    assign size_n  = size == 2'd3 ? 2'd2 : size;
    assign wstrb_n = size_n == 2'd0 ? 4'b0001 << addr[1:0] :
                     size_n == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign rd_done = state == RD_DATA && rvalid && !rst;
    assign wr_done = state == WR_RESP && bvalid && !rst;
    assign data_ok = rd_done || wr_done;
    assign rdata   = rd_done ? rdata_axi : '0;
    assign addr_ok = state == IDLE && req && !rst;
    assign arid      = AXI_ID;
    assign awid      = AXI_ID;
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arsize    = {1'b0, size_q};
    assign awsize    = {1'b0, size_q};
    assign wdata_axi = wdata_q;
    assign wstrb     = wstrb_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    size_q  <= size_n;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb_n;
                    if (wr) begin
                        state   <= WR_REQ;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else begin
                        state   <= RD_ADDR;
                        arvalid <= 1'b1;
                    end
                end
                RD_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (rvalid) begin
                    rready <= 1'b0;
                    state  <= IDLE;
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // both channels may complete in the same cycle
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state   <= WR_RESP;
                        bready  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WR_RESP: if (bvalid) begin
                    bready <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i_cache_axi_bridge.sv
// tb_i_cache_axi_bridge: randomized bench with a transaction-level timing model
module tb_i_cache_axi_bridge;
    logic        clk = 1'b0, rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, araddr, awaddr, wdata_axi, rdata_axi;
    logic        addr_ok, data_ok, arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  arid, awid, wstrb;
    logic [2:0]  arsize, awsize;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    i_cache_axi_bridge dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    // bytes touched: offset..offset+n-1 within the word, word accesses cover all lanes
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] off);
        int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        int o = int'(off);
        logic [3:0] m = '0;
        if (n == 4) return 4'b1111;
        for (int b = 0; b < 4; b++) if (b >= o && b < o + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [2:0] exp_size(input logic [1:0] sz);
        return sz == 2'd3 ? 3'd2 : {1'b0, sz};
    endfunction

    function automatic logic [6:0] ctl();
        return {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok};
    endfunction

    task automatic drive_idle();
        req = 1'b0; arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata_axi = $urandom;
    endtask

    task automatic accept(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_idle();
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        #1;
        total++;
        if (ctl() !== 7'b0000010) begin
            bad++;
            $display("FAIL accept a=%h ctl=%b want 0000010", a, ctl());
        end
    endtask

    task automatic run_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input int ar_w, input int r_w, input logic keep);
        accept(1'b0, sz, a, $urandom);
        for (int k = 0; k <= ar_w; k++) begin
            @(negedge clk);
            req = keep; addr = $urandom; wdata = $urandom;
            arready = (k == ar_w);
            #1;
            total++;
            if (ctl() !== 7'b1000000 || araddr !== a || arsize !== exp_size(sz) || arid !== 4'd0) begin
                bad++;
                $display("FAIL rd_addr k=%0d ctl=%b araddr=%h arsize=%0d want ctl=1000000 araddr=%h arsize=%0d",
                         k, ctl(), araddr, arsize, a, exp_size(sz));
            end
        end
        for (int j = 0; j <= r_w; j++) begin
            @(negedge clk);
            arready = 1'($urandom);
            rvalid = (j == r_w);
            rdata_axi = rvalid ? d : $urandom;
            #1;
            total++;
            if (ctl() !== {6'b010000, rvalid} || (rvalid && rdata !== d)) begin
                bad++;
                $display("FAIL rd_data j=%0d ctl=%b rdata=%h want ctl=%b rdata=%h",
                         j, ctl(), rdata, {6'b010000, rvalid}, d);
            end
        end
    endtask

    task automatic run_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                             input int aw_w, input int w_w, input int b_w);
        int last = aw_w > w_w ? aw_w : w_w;
        logic [6:0] want;
        accept(1'b1, sz, a, d);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            req = 1'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom); wr = 1'($urandom);
            awready = k >= aw_w;
            wready = k >= w_w;
            #1;
            want = {2'b00, 1'(k <= aw_w), 1'(k <= w_w), 3'b000};
            total++;
            if (ctl() !== want || awid !== 4'd0 ||
                (k <= aw_w && (awaddr !== a || awsize !== exp_size(sz))) ||
                (k <= w_w && (wdata_axi !== d || wstrb !== exp_strb(sz, a[1:0])))) begin
                bad++;
                $display("FAIL wr_req k=%0d ctl=%b awaddr=%h awsize=%0d wdata=%h wstrb=%b want ctl=%b awaddr=%h awsize=%0d wdata=%h wstrb=%b",
                         k, ctl(), awaddr, awsize, wdata_axi, wstrb, want, a, exp_size(sz), d, exp_strb(sz, a[1:0]));
            end
        end
        for (int j = 0; j <= b_w; j++) begin
            @(negedge clk);
            req = 1'b0;
            awready = 1'($urandom); wready = 1'($urandom);
            bvalid = (j == b_w);
            #1;
            total++;
            if (ctl() !== {6'b000010, bvalid}) begin
                bad++;
                $display("FAIL wr_resp j=%0d ctl=%b want %b", j, ctl(), {6'b000010, bvalid});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle(); wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        @(negedge clk);
        req = 1'b1;
        #1;
        total++;
        if (addr_ok !== 1'b0 || data_ok !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold addr_ok=%b data_ok=%b want 0 0", addr_ok, data_ok);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        total++;
        if (ctl() !== 7'b0 || rdata !== '0 || wstrb !== '0 || araddr !== '0 || awaddr !== '0 ||
            wdata_axi !== '0 || arsize !== '0 || arid !== '0 || awid !== '0) begin
            bad++;
            $display("FAIL reset ctl=%b rdata=%h wstrb=%b araddr=%h wdata=%h want all zero",
                     ctl(), rdata, wstrb, araddr, wdata_axi);
        end
    endtask

    task automatic test_read_zero_wait();
        run_read(32'hBFC0_0000, 2'd2, 32'h3C08_BFC0, 0, 0, 1'b0);
    endtask

    task automatic test_read_backpressure();
        run_read(32'h8000_1234, 2'd2, 32'hDEAD_BEEF, 5, 3, 1'b0);
    endtask

    task automatic test_write_split();
        run_write(32'h0000_0013, 2'd0, 32'hAB00_0000, 1, 0, 2);
    endtask

    task automatic test_write_sizes();
        run_write(32'h0000_0102, 2'd1, 32'h5678_0000, 0, 0, 0);
        run_write(32'h0000_0200, 2'd3, 32'h1122_3344, 2, 2, 1);
    endtask

    task automatic test_back_to_back();
        run_read(32'h0000_1000, 2'd2, 32'h0102_0304, 0, 0, 1'b1);
        run_read(32'h0000_1004, 2'd2, 32'h0506_0708, 1, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        accept(1'b0, 2'd2, 32'h0000_2000, '0);
        @(negedge clk);
        req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0;
        #1;
        total++;
        if (ctl() !== 7'b0100000) begin
            bad++;
            $display("FAIL mid_wait ctl=%b want 0100000", ctl());
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b0; rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D;
            #1;
            total++;
            if (ctl() !== 7'b0) begin
                bad++;
                $display("FAIL mid_reset i=%0d ctl=%b want 0000000", i, ctl());
            end
        end
        run_read(32'h0000_3000, 2'd2, 32'h7777_8888, 0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if (1'($urandom))
                run_read($urandom, 2'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
            else
                run_write($urandom, 2'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_read_backpressure();
        test_write_split();
        test_write_sizes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i_cache_axi_bridge.md
# i_cache_axi_bridge

Single-outstanding bridge from the instruction cache's SRAM-like miss port (the `cache_inst_*` bus) to an AXI master port. It sits directly downstream of the direct-mapped I-cache and upstream of the SoC AXI interconnect. It converts one SRAM-like request at a time into one single-beat AXI read (AR/R) or write (AW/W/B) transaction, and returns completion via `data_ok`.

## Interface
- `AXI_ID`, default 4'd0: constant driven on `arid`/`awid`.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: SRAM-like request valid.
- `wr` in 1: 1 = write, 0 = read.
- `size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as 2.
- `addr` in 32: byte address, passed unmodified to AXI.
- `wdata` in 32: write data, lane-aligned as on the AXI bus.
- `rdata` out 32: read data, valid only while `data_ok`.
- `addr_ok` out 1: request accepted this cycle.
- `data_ok` out 1: transaction complete, one-cycle pulse.
- `arid` out 4: `AXI_ID`.
- `araddr` out 32: latched address.
- `arsize` out 3: {1'b0, latched size}.
- `arvalid` out 1: read address valid.
- `arready` in 1: read address ready.
- `rdata_axi` in 32: AXI read data.
- `rvalid` in 1: read data valid.
- `rready` out 1: read data ready.
- `awid` out 4: `AXI_ID`.
- `awaddr` out 32: latched address.
- `awsize` out 3: {1'b0, latched size}.
- `awvalid` out 1: write address valid.
- `awready` in 1: write address ready.
- `wdata_axi` out 32: latched wdata.
- `wstrb` out 4: byte strobes.
- `wvalid` out 1: write data valid.
- `wready` in 1: write data ready.
- `bvalid` in 1: write response valid.
- `bready` out 1: write response ready.
- Not connected here: `arlen`/`awlen` = 0, `arburst`/`awburst` = INCR, `wlast` = 1, `rresp`/`bresp`. These are tied in the top-level wrapper.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - `addr_ok = req` (combinational).
  - On `req`, latch `wr`, `size`, `addr`, `wdata`.
  - Next state is RD_ADDR if `wr` = 0, else WR_REQ.
- RD_ADDR: `arvalid` = 1, held stable until `arready`, then go to RD_DATA.
- RD_DATA:
  - `rready` = 1.
  - On `rvalid`: `data_ok` = 1, `rdata = rdata_axi` (combinational pass-through), go to IDLE.
- WR_REQ:
  - `awvalid` and `wvalid` assert together.
  - Each drops independently after its own handshake; `aw_done`/`w_done` flags record it.
  - When both are done, including in the same cycle, go to WR_RESP.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`: `data_ok` = 1, go to IDLE.
- wstrb:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << addr[1:0]
  - size 2/3: 4'b1111
- AXI error responses are ignored; completion is signalled normally.

## Timing
- Reset values: state IDLE; `addr_ok`, `data_ok`, `arvalid`, `rready`, `awvalid`, `wvalid`, `bready` all 0; `rdata`, `wstrb` 0; latched address/data 0; done flags 0.
- Reset mid-transaction: returns to IDLE on the next edge; the in-flight AXI transaction is abandoned, and the interconnect is reset in the same cycle.
- `addr_ok` is asserted only in IDLE, so it never coincides with `data_ok`. A new request is accepted no earlier than the cycle after `data_ok`.
- Minimum read latency: accept at cycle N, `arvalid` at N+1 (`arready` = 1), `rready` at N+2 with `rvalid` → `data_ok` at N+2.
- Minimum write latency: accept at N, AW/W at N+1, `bvalid` at N+2 → `data_ok` at N+2.
- All AXI valid outputs are registered state decodes, never combinational from AXI ready inputs.
- AXI payloads (`araddr`, `arsize`, `awaddr`, `awsize`, `wdata_axi`, `wstrb`) are stable from valid until handshake.
- `req` deasserting after acceptance has no effect; `addr` may change freely after `addr_ok`.

## Test plan
- Read, zero-wait: `req`=1, `wr`=0, `addr`=0xBFC00000, `size`=2; `arready`=1; `rvalid` with 0x3C08BFC0 one cycle later → `addr_ok` at N, `araddr`=0xBFC00000, `arsize`=3'b010, `data_ok` at N+2 with `rdata`=0x3C08BFC0.
- Read backpressure: `arready` low for 5 cycles, `rvalid` delayed 3 more cycles → `arvalid`/`araddr` stable throughout, exactly one `data_ok`, `addr_ok` stays low until IDLE.
- Write with split handshakes: `size`=0, `addr`=0x00000013 → `wstrb`=4'b1000. `wready` one cycle before `awready`: `wvalid` drops first, `bready` rises only after both are done, `data_ok` on `bvalid`.
- Half-word write at `addr` 0x102 → `wstrb`=4'b1100, `awsize`=3'b001; `size`=3 word write → `wstrb`=4'b1111, `awsize`=3'b010.
- Back-to-back: `req` held high for two reads → second `addr_ok` exactly one cycle after first `data_ok`, never the same cycle.
- Reset mid-RD_DATA: assert `rst` while waiting on `rvalid` → next cycle all valid/ready outputs are 0, state IDLE, no `data_ok`; a later `rvalid` is ignored.
